// File: rtl/gnn_mac_seq.sv
// Sequencer for a 4-node GNN MAC array: loads shared weights once,
// then fetches, fires and writes back each node group in turn.
module gnn_mac_seq #(
  parameter int NUM_GROUPS = 4,
  parameter int ADDR_W     = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              w_load,
  output logic              feat_rd_en,
  output logic [ADDR_W-1:0] feat_addr,
  input  logic              feat_valid,
  output logic              mac_in_ready,
  input  logic              mac_ready,
  output logic              res_wr_en,
  output logic [ADDR_W-1:0] res_addr
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_GROUPS - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WLOAD,
    S_FETCH,
    S_WDATA,
    S_FIRE,
    S_WMAC,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] g_q, g_d;
  logic [TW-1:0] to_q, to_d;
  logic [TW-1:0] to_inc;

  assign to_inc = (to_q == TMAX) ? to_q : to_q + TW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    to_d    = to_q;
    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          g_d     = '0;
          state_d = S_WLOAD;
        end
      end
      S_WLOAD: state_d = S_FETCH;
      S_FETCH: state_d = S_WDATA;
      S_WDATA: begin
        if (feat_valid) state_d = S_FIRE;
      end
      S_FIRE: begin
        to_d    = '0;
        state_d = S_WMAC;
      end
      // the count that lands on TIMEOUT decides the error
      S_WMAC: begin
        to_d = to_inc;
        if (mac_ready) begin
          state_d = S_WRITE;
        end else if (to_inc == TMAX) begin
          state_d = S_ERR;
        end
      end
      S_WRITE: begin
        if (g_q == LAST) begin
          state_d = S_DONE;
        end else begin
          g_d     = g_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    w_load       = 1'b0;
    feat_rd_en   = 1'b0;
    mac_in_ready = 1'b0;
    res_wr_en    = 1'b0;
    unique case (state_q)
      S_IDLE:  busy = 1'b0;
      S_ERR: begin
        busy = 1'b0;
        err  = 1'b1;
      end
      S_WLOAD: w_load       = 1'b1;
      S_FETCH: feat_rd_en   = 1'b1;
      S_FIRE:  mac_in_ready = 1'b1;
      S_WRITE: res_wr_en    = 1'b1;
      S_DONE:  done         = 1'b1;
      default: ;
    endcase
  end

  assign feat_addr = g_q;
  assign res_addr  = g_q;

endmodule

// File: tb/tb_gnn_mac_seq.sv
// Bench for gnn_mac_seq: per-cycle schedule model from the group timing
// rules, plus literal event counts and write-address lists.
module tb_gnn_mac_seq;

  localparam int AW = 4;
  localparam int TO = 8;
  localparam int N  = 400;
  localparam bit H  = 1'b1;
  localparam bit L  = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_w, st_w, fv_w, mr_w;
  logic [1:0] busy_w, done_w, err_w, wl_w, rd_w, ir_w, wr_w;
  logic [AW-1:0] fa [2];
  logic [AW-1:0] ra [2];

  gnn_mac_seq #(.NUM_GROUPS(4), .ADDR_W(AW), .TIMEOUT(TO)) u0 (
    .clk(clk), .rst(rst_w[0]), .start(st_w[0]),
    .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]),
    .w_load(wl_w[0]), .feat_rd_en(rd_w[0]), .feat_addr(fa[0]),
    .feat_valid(fv_w[0]), .mac_in_ready(ir_w[0]),
    .mac_ready(mr_w[0]), .res_wr_en(wr_w[0]), .res_addr(ra[0])
  );

  gnn_mac_seq #(.NUM_GROUPS(1), .ADDR_W(AW), .TIMEOUT(TO)) u1 (
    .clk(clk), .rst(rst_w[1]), .start(st_w[1]),
    .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]),
    .w_load(wl_w[1]), .feat_rd_en(rd_w[1]), .feat_addr(fa[1]),
    .feat_valid(fv_w[1]), .mac_in_ready(ir_w[1]),
    .mac_ready(mr_w[1]), .res_wr_en(wr_w[1]), .res_addr(ra[1])
  );

  logic [14:0] ex [2][N];
  bit chk [2][N];
  bit i_st [2][N];
  bit i_rs [2][N];
  bit i_fv [2][N];
  bit i_mr [2][N];
  int t [2];
  logic [AW-1:0] cg [2];
  bit cerr [2];

  int total = 0;
  int bad = 0;

  task automatic emit(input int k, input bit b, dn, wl, rd, ir, wr,
                      input bit st, rs, v, r);
    ex[k][t[k]]   = {b, dn, cerr[k], wl, rd, ir, wr, cg[k], cg[k]};
    chk[k][t[k]]  = 1'b1;
    i_st[k][t[k]] = st;
    i_rs[k][t[k]] = rs;
    i_fv[k][t[k]] = v;
    i_mr[k][t[k]] = r;
    t[k]++;
  endtask

  task automatic idle_c(input int k, input int n, input bit go);
    for (int i = 0; i < n; i++)
      emit(k, L, L, L, L, L, L, go && (i == n - 1), L, L, L);
  endtask

  task automatic rst_c(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      emit(k, L, L, L, L, L, L, L, H, L, L);
      cg[k]   = '0;
      cerr[k] = 1'b0;
    end
  endtask

  // nz: bit0 stale fv/mr in FIRE, bit1 fv/mr tied high,
  // bit2 start pulsed through group 1; kind 1 timeout, 2 reset
  task automatic run(input int k, input int ng, input int d,
                     input int m, input int nz, input int fg,
                     input int kind);
    bit tie;
    bit sn;
    tie     = nz[1];
    cerr[k] = 1'b0;
    cg[k]   = '0;
    emit(k, H, L, H, L, L, L, L, L, tie, tie);
    for (int g = 0; g < ng; g++) begin
      sn    = nz[2] && (g == 1);
      cg[k] = AW'(g);
      emit(k, H, L, L, H, L, L, sn, L, tie, tie);
      for (int i = 1; i <= d; i++)
        emit(k, H, L, L, L, L, L, sn, L, tie || (i == d), tie);
      emit(k, H, L, L, L, H, L, sn, L, tie || nz[0], tie || nz[0]);
      if (g == fg && kind == 1) begin
        for (int i = 0; i < TO; i++)
          emit(k, H, L, L, L, L, L, sn, L, L, L);
        cerr[k] = 1'b1;
        return;
      end
      if (g == fg && kind == 2) begin
        emit(k, H, L, L, L, L, L, L, H, L, L);
        cg[k]   = '0;
        cerr[k] = 1'b0;
        return;
      end
      for (int i = 1; i <= m; i++)
        emit(k, H, L, L, L, L, L, sn, L, tie, tie || (i == m));
      emit(k, H, L, L, L, L, H, sn, L, tie, tie);
    end
    emit(k, H, H, L, L, L, L, L, L, tie, tie);
  endtask

  task automatic check_i(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  int wl_n [2];
  int wr_n [2];
  int dn_n [2];
  int first_wr, first_err, first_dn;
  logic [AW-1:0] wq0 [$];
  logic [AW-1:0] wq1 [$];
  int exp_a0 [18] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3,
                      0, 1, 0, 1, 2, 3};

  initial begin
    logic [14:0] got;
    int last;
    rst_w = '0; st_w = '0; fv_w = '0; mr_w = '0;
    for (int k = 0; k < 2; k++) begin
      t[k] = 0; cg[k] = '0; cerr[k] = 1'b0;
      wl_n[k] = 0; wr_n[k] = 0; dn_n[k] = 0;
      for (int c = 0; c < N; c++) begin
        ex[k][c] = '0; chk[k][c] = 1'b0;
        i_st[k][c] = 1'b0; i_rs[k][c] = 1'b0;
        i_fv[k][c] = 1'b0; i_mr[k][c] = 1'b0;
      end
    end
    first_wr = -1; first_err = -1; first_dn = -1;

    rst_c(0, 2);
    idle_c(0, 2, H);
    run(0, 4, 1, 2, 1, -1, 0);
    idle_c(0, 3, H);
    run(0, 4, 2, 1, 0, 0, 1);
    idle_c(0, 4, H);
    run(0, 4, 1, 1, 4, -1, 0);
    idle_c(0, 2, H);
    run(0, 4, 1, 1, 2, -1, 0);
    idle_c(0, 2, H);
    run(0, 4, 1, 2, 0, 2, 2);
    idle_c(0, 3, H);
    run(0, 4, 3, 3, 0, -1, 0);
    idle_c(0, 2, H);
    run(0, 4, 1, 1, 0, 0, 1);
    idle_c(0, 2, L);
    rst_c(0, 1);
    idle_c(0, 3, L);

    rst_c(1, 2);
    idle_c(1, 2, H);
    run(1, 1, 1, 1, 0, -1, 0);
    idle_c(1, 3, L);

    chk[0][0] = 1'b0;
    chk[1][0] = 1'b0;
    last = (t[0] > t[1]) ? t[0] : t[1];

    for (int c = 0; c < last; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (c < t[k] && chk[k][c]) begin
          got = {busy_w[k], done_w[k], err_w[k], wl_w[k], rd_w[k],
                 ir_w[k], wr_w[k], fa[k], ra[k]};
          total++;
          if (got !== ex[k][c]) begin
            bad++;
            $display("FAIL outputs dut%0d cyc%0d got=%h want=%h",
                     k, c, got, ex[k][c]);
          end
          if (wl_w[k] === 1'b1) wl_n[k]++;
          if (done_w[k] === 1'b1) dn_n[k]++;
          if (wr_w[k] === 1'b1) begin
            wr_n[k]++;
            if (k == 0) wq0.push_back(ra[k]);
            else wq1.push_back(ra[k]);
          end
          if (k == 0 && wr_w[0] === 1'b1 && first_wr < 0) first_wr = c;
          if (k == 0 && err_w[0] === 1'b1 && first_err < 0) first_err = c;
          if (k == 0 && done_w[0] === 1'b1 && first_dn < 0) first_dn = c;
        end
      end
      for (int k = 0; k < 2; k++) begin
        rst_w[k] = (c < t[k]) ? i_rs[k][c] : 1'b0;
        st_w[k]  = (c < t[k]) ? i_st[k][c] : 1'b0;
        fv_w[k]  = (c < t[k]) ? i_fv[k][c] : 1'b0;
        mr_w[k]  = (c < t[k]) ? i_mr[k][c] : 1'b0;
      end
    end

    check_i("wload_count0", wl_n[0], 7);
    check_i("write_count0", wr_n[0], 18);
    check_i("done_count0", dn_n[0], 4);
    check_i("first_write_cyc", first_wr, 10);
    check_i("first_done_cyc", first_dn, 29);
    check_i("first_err_cyc", first_err, 46);
    check_i("addr_list_len0", wq0.size(), 18);
    for (int i = 0; i < 18 && i < wq0.size(); i++)
      check_i($sformatf("addr0_%0d", i), int'(wq0[i]), exp_a0[i]);
    check_i("wload_count1", wl_n[1], 1);
    check_i("write_count1", wr_n[1], 1);
    check_i("done_count1", dn_n[1], 1);
    check_i("addr_list_len1", wq1.size(), 1);
    if (wq1.size() > 0) check_i("addr1_0", int'(wq1[0]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
